// File: rtl/operand_stack_exec.sv
// operand_stack_exec: operand stack with a push path and an external-ALU execute path.
// The stack lives in a register array; tos/depth/fault come from registered state.
package stackcpu_defs;
   localparam int DATA_WIDTH_DEF = 16;
   typedef enum logic [3:0] {
      PUSH_IMMEDIATE = 4'd0, ADD, SUB, MUL, DIV, MOD, AND, OR, INVERT
   } opcode_t;
endpackage

module operand_stack_exec import stackcpu_defs::*; #(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int STACK_DEPTH = 16,
   localparam int AW = $clog2(STACK_DEPTH),
   localparam int DW = AW + 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         instr_valid,
   output logic                         instr_ready,
   input  opcode_t                      instr_opcode,
   input  logic signed [DATA_WIDTH-1:0] instr_imm,
   output opcode_t                      alu_opcode,
   output logic signed [DATA_WIDTH-1:0] alu_operand1,
   output logic signed [DATA_WIDTH-1:0] alu_operand2,
   input  logic signed [DATA_WIDTH-1:0] alu_result,
   input  logic                         alu_error,
   output logic signed [DATA_WIDTH-1:0] tos,
   output logic [DW-1:0]                depth,
   output logic [1:0]                   fault,
   input  logic                         clear_fault
);
   typedef enum logic [1:0] {IDLE, EXEC, WRITE, FAULT} state_t;
   state_t state;
   opcode_t op_r;
   logic signed [DATA_WIDTH-1:0] mem [STACK_DEPTH];
   logic signed [DATA_WIDTH-1:0] res_r, wdata;
   logic err_r, binary_in, binary_r, accept_push, we, exec;
   logic [AW-1:0] top_i, sec_i, waddr;

   assign top_i       = AW'(depth - 1'b1);
   assign sec_i       = AW'(depth - 2'd2);
   assign binary_in   = instr_opcode inside {ADD, SUB, MUL, DIV, MOD, AND, OR};
   assign binary_r    = op_r inside {ADD, SUB, MUL, DIV, MOD, AND, OR};
   assign accept_push = state == IDLE && instr_valid && instr_opcode == PUSH_IMMEDIATE
                        && depth != DW'(STACK_DEPTH);
   // rst_n gates the write so an edge seen while reset is held never touches the array
   assign we          = rst_n && (accept_push || (state == WRITE && !err_r));
   assign waddr       = accept_push ? depth[AW-1:0] : (binary_r ? sec_i : top_i);
   assign wdata       = accept_push ? instr_imm : res_r;
   assign exec        = state == EXEC;

   assign instr_ready  = state == IDLE;
   assign alu_opcode   = exec ? op_r : PUSH_IMMEDIATE;
   assign alu_operand1 = exec && depth >= DW'(2) ? mem[sec_i] : '0;
   assign alu_operand2 = exec && depth != '0 ? mem[top_i] : '0;
   assign tos          = depth != '0 ? mem[top_i] : '0;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         depth <= '0;
         fault <= 2'b00;
         op_r  <= PUSH_IMMEDIATE;
         res_r <= '0;
         err_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (instr_valid) begin
               op_r <= instr_opcode;
               if (instr_opcode == PUSH_IMMEDIATE) begin
                  if (accept_push) depth <= depth + 1'b1;
                  else begin
                     fault <= 2'b10;
                     state <= FAULT;
                  end
               end else if (!(binary_in || instr_opcode == INVERT)) begin
                  fault <= 2'b11;
                  state <= FAULT;
               end else if (depth >= (binary_in ? DW'(2) : DW'(1))) begin
                  state <= EXEC;
               end else begin
                  fault <= 2'b01;
                  state <= FAULT;
               end
            end
            EXEC: begin
               res_r <= alu_result;
               err_r <= alu_error;
               state <= WRITE;
            end
            WRITE: if (err_r) begin
               fault <= 2'b11;
               state <= FAULT;
            end else begin
               if (binary_r) depth <= depth - 1'b1;
               state <= IDLE;
            end
            FAULT: if (clear_fault) begin
               fault <= 2'b00;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
